// File: rtl/mp_add_pkg.sv
// Shared types and constants for the multi-precision add sequencer.
// One word_t is the native width of the Brent-Kung adder.
package mp_add_pkg;

  localparam int WORD_W    = 64;
  localparam int MAX_WORDS = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

endpackage

// File: rtl/brent_kung_adder.sv
// Parallel-prefix (Brent-Kung) adder with carry in and carry out.
// WIDTH must be a power of two.
module brent_kung_adder #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  always_comb begin
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] gg;
    logic [WIDTH-1:0] pp;
    logic [WIDTH-1:0] c;
    p  = A ^ B;
    gg = A & B;
    pp = p;
    // up-sweep builds prefixes at 2^k-1, down-sweep fills the rest
    for (int d = 1; d < WIDTH; d = d * 2) begin
      for (int i = 2 * d - 1; i < WIDTH; i = i + 2 * d) begin
        gg[i] = gg[i] | (pp[i] & gg[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    end
    for (int d = WIDTH / 4; d >= 1; d = d / 2) begin
      for (int i = 3 * d - 1; i < WIDTH; i = i + 2 * d) begin
        gg[i] = gg[i] | (pp[i] & gg[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    end
    c[0] = Cin;
    for (int i = 1; i < WIDTH; i++) begin
      c[i] = gg[i-1] | (pp[i-1] & Cin);
    end
    Sum  = p ^ c;
    Cout = gg[WIDTH-1] | (pp[WIDTH-1] & Cin);
  end

endmodule

// File: rtl/mp_add_sequencer.sv
// Multi-precision add/subtract sequencer: one word per cycle,
// carry chained through a register, registered result stream.
module mp_add_sequencer #(
  parameter int WIDTH     = 64,
  parameter int MAX_WORDS = 16,
  parameter int LEN_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len_m1,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_last,
  output logic             carry_out
);
  import mp_add_pkg::*;

  state_t           state;
  state_t           nxt;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_in;
  logic             sub_q;
  logic             carry_reg;
  logic             hs;
  logic             last;
  logic             out_hs;
  logic             cout;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] sum;

  assign len_in = (32'(len_m1) > 32'(MAX_WORDS - 1)) ?
                  LEN_W'(MAX_WORDS - 1) : len_m1;

  assign hs     = op_valid && op_ready;
  assign last   = (cnt == len_q);
  assign out_hs = res_valid && res_ready;
  assign b_in   = sub_q ? ~op_b : op_b;

  brent_kung_adder #(
    .WIDTH(WIDTH)
  ) u_add (
    .A   (op_a),
    .B   (b_in),
    .Cin (carry_reg),
    .Sum (sum),
    .Cout(cout)
  );

  always_comb begin
    nxt      = state;
    busy     = 1'b0;
    op_ready = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) nxt = RUN;
      end
      RUN: begin
        busy     = 1'b1;
        op_ready = !res_valid || res_ready;
        if (hs && last) nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (out_hs) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done      <= 1'b0;
      len_q     <= '0;
      sub_q     <= 1'b0;
      carry_reg <= 1'b0;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_last  <= 1'b0;
      carry_out <= 1'b0;
    end else begin
      done <= (state == DRAIN) && out_hs;
      // subtraction is A + ~B + 1, so the chain seeds with sub
      if (state == IDLE && start) begin
        len_q     <= len_in;
        sub_q     <= sub;
        carry_reg <= sub;
        cnt       <= '0;
      end
      if (hs) begin
        res_sum   <= sum;
        res_last  <= last;
        res_valid <= 1'b1;
        carry_reg <= cout;
        cnt       <= cnt + 1'b1;
        if (last) carry_out <= cout;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule
